// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Round-robin front end that lets two requesters share one external
//   combinational ALU. Each accepted op runs IDLE -> EXEC -> RESP, so the ALU
//   can take a new op at most once every three cycles.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   rN_req_valid/ready         request handshake, N = 0,1
//   rN_a, rN_b, rN_ctrl        operands and ALU control code
//   rN_resp_valid/ready        response handshake
//   rN_result, rN_flags        captured result and {v,c,n,z}, shared by both
//                              requesters; qualified only by the owner's
//                              resp_valid
//   alu_a, alu_b, alu_ctrl     registered operands to the ALU
//   alu_result, alu_flags      combinational ALU outputs
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic [WIDTH-1:0]  r0_a,
    input  logic [WIDTH-1:0]  r0_b,
    input  logic [CTRL_W-1:0] r0_ctrl,
    output logic              r0_resp_valid,
    input  logic              r0_resp_ready,
    output logic [WIDTH-1:0]  r0_result,
    output logic [FLAG_W-1:0] r0_flags,

    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic [WIDTH-1:0]  r1_a,
    input  logic [WIDTH-1:0]  r1_b,
    input  logic [CTRL_W-1:0] r1_ctrl,
    output logic              r1_resp_valid,
    input  logic              r1_resp_ready,
    output logic [WIDTH-1:0]  r1_result,
    output logic [FLAG_W-1:0] r1_flags,

    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [FLAG_W-1:0] alu_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q;
    logic              owner_q;
    logic              grant;      // 0 -> r0, 1 -> r1
    logic              accept;
    logic              resp_done;
    logic [WIDTH-1:0]  result_q;
    logic [FLAG_W-1:0] flags_q;

    // On a tie the requester that did not win last time gets the slot; with a
    // single valid requester the grant simply follows it.
    assign grant = (r0_req_valid && r1_req_valid) ? ~last_grant_q : r1_req_valid;

    // Ready is gated by the requester's own valid so an idle requester never
    // sees ready, even though grant defaults to r0 when nobody asks.
    assign r0_req_ready = (state_q == IDLE) && r0_req_valid && !grant;
    assign r1_req_ready = (state_q == IDLE) && r1_req_valid &&  grant;
    assign accept       = r0_req_ready || r1_req_ready;

    assign r0_resp_valid = (state_q == RESP) && !owner_q;
    assign r1_resp_valid = (state_q == RESP) &&  owner_q;

    // Only the owner's resp_ready can close the response.
    assign resp_done = owner_q ? r1_resp_valid && r1_resp_ready
                               : r0_resp_valid && r0_resp_ready;

    assign r0_result = result_q;
    assign r1_result = result_q;
    assign r0_flags  = flags_q;
    assign r1_flags  = flags_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;   // r0 wins the first tie
            owner_q      <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_ctrl     <= '0;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= grant;
                last_grant_q <= grant;
                alu_a        <= grant ? r1_a    : r0_a;
                alu_b        <= grant ? r1_b    : r0_b;
                alu_ctrl     <= grant ? r1_ctrl : r0_ctrl;
            end
            // ALU has had the whole EXEC cycle to settle on the registered
            // operands; the captured value stays put through RESP.
            if (state_q == EXEC) begin
                result_q <= alu_result;
                flags_q  <= alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req_valid, r0_req_ready, r0_resp_valid, r0_resp_ready;
    logic        r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_ready;
    logic [31:0] r0_a, r0_b, r1_a, r1_b, r0_result, r1_result;
    logic [3:0]  r0_ctrl, r1_ctrl, r0_flags, r1_flags;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl, alu_flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
        .r0_a(r0_a), .r0_b(r0_b), .r0_ctrl(r0_ctrl),
        .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
        .r0_result(r0_result), .r0_flags(r0_flags),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
        .r1_a(r1_a), .r1_b(r1_b), .r1_ctrl(r1_ctrl),
        .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
        .r1_result(r1_result), .r1_flags(r1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    // Stand-in for the external ALU: 0 add, 1 sub, 2 and, 3 or, else xor.
    logic [32:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        case (alu_ctrl)
            4'd0:    alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1:    alu_wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            4'd2:    alu_wide = {1'b0, alu_a & alu_b};
            4'd3:    alu_wide = {1'b0, alu_a | alu_b};
            default: alu_wide = {1'b0, alu_a ^ alu_b};
        endcase
        alu_result   = alu_wide[31:0];
        alu_flags[3] = (alu_ctrl == 4'd0) ? (alu_a[31] == alu_b[31]) && (alu_wide[31] != alu_a[31]) :
                       (alu_ctrl == 4'd1) ? (alu_a[31] != alu_b[31]) && (alu_wide[31] != alu_a[31]) : 1'b0;
        alu_flags[2] = alu_wide[32];
        alu_flags[1] = alu_wide[31];
        alu_flags[0] = (alu_wide[31:0] == 32'd0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r0_req_valid = 0; r1_req_valid = 0;
        r0_resp_ready = 0; r1_resp_ready = 0;
        r0_a = 0; r0_b = 0; r0_ctrl = 0;
        r1_a = 0; r1_b = 0; r1_ctrl = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        #1;
    endtask

    function automatic logic rdy(input int n);
        return (n == 1) ? r1_req_ready : r0_req_ready;
    endfunction

    // One op from IDLE with resp_ready held high; checks the cycle-by-cycle
    // timing (accept cycle T, EXEC at T+1, RESP at T+2, IDLE at T+3).
    task automatic run_op(input int n, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] ctrl, input logic [31:0] er,
                          input logic [3:0] ef, input string tag);
        int k;
        if (n == 1) begin
            r1_a = a; r1_b = b; r1_ctrl = ctrl; r1_req_valid = 1; r1_resp_ready = 1;
        end else begin
            r0_a = a; r0_b = b; r0_ctrl = ctrl; r0_req_valid = 1; r0_resp_ready = 1;
        end
        #1;
        k = 0;
        while (!rdy(n) && k < 8) begin
            step();
            k++;
        end
        chk({tag, "_ready"}, rdy(n), 1'b1);
        step();
        r0_req_valid = 0; r1_req_valid = 0;
        #1;
        chk({tag, "_exec_nores"}, {r0_resp_valid, r1_resp_valid}, 2'b00);
        chk({tag, "_alu_a"}, alu_a, a);
        step();
        chk({tag, "_resp_valid"}, {r1_resp_valid, r0_resp_valid}, (n == 1) ? 2'b10 : 2'b01);
        chk({tag, "_result"}, (n == 1) ? r1_result : r0_result, er);
        chk({tag, "_flags"}, (n == 1) ? r1_flags : r0_flags, ef);
        step();
        chk({tag, "_done"}, {r0_resp_valid, r1_resp_valid}, 2'b00);
        r0_resp_ready = 0; r1_resp_ready = 0;
    endtask

    initial begin
        int gnt_who[4];
        int gnt_cyc[4];
        int ng;
        logic [31:0] held;

        idle_inputs();
        rst_n = 0;
        #3;
        chk("rst_outputs", {r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid}, 4'b0000);
        chk("rst_alu", {alu_a, alu_b}, 64'd0);
        chk("rst_result", {r0_result, r0_flags}, 36'd0);
        step();
        rst_n = 1;
        step();
        chk("idle_no_ready", {r0_req_ready, r1_req_ready}, 2'b00);

        // Directed ops
        run_op(0, 32'd5, 32'd3, 4'b0000, 32'd8, 4'b0000, "t1_add");
        run_op(1, 32'd5, 32'd5, 4'b0001, 32'd0, 4'b0101, "t2_sub");
        run_op(0, 32'h7FFF_FFFF, 32'd1, 4'b0000, 32'h8000_0000, 4'b1010, "t3_ovf");

        // Fairness: both valid from reset, responses consumed immediately
        do_reset();
        r0_req_valid = 1; r1_req_valid = 1; r0_resp_ready = 1; r1_resp_ready = 1;
        r0_a = 32'd1; r1_a = 32'd2;
        #1;
        ng = 0;
        for (int i = 0; i < 20 && ng < 4; i++) begin
            if (r0_req_ready && r1_req_ready) chk("t4_both_ready", 1'b1, 1'b0);
            if (r0_req_ready || r1_req_ready) begin
                gnt_who[ng] = r1_req_ready ? 1 : 0;
                gnt_cyc[ng] = i;
                ng++;
            end
            step();
        end
        chk("t4_grant_count", ng, 4);
        for (int g = 0; g < 4 && g < ng; g++) begin
            chk($sformatf("t4_grant%0d_who", g), gnt_who[g], g % 2);
            if (g > 0) chk($sformatf("t4_grant%0d_gap", g), gnt_cyc[g] - gnt_cyc[g-1], 3);
        end
        idle_inputs();
        repeat (4) step();

        // Held response: r0 wins the tie, r1 waits through a stalled RESP
        do_reset();
        r0_a = 32'd10; r0_b = 32'd20; r0_ctrl = 4'd0; r0_req_valid = 1;
        r1_a = 32'd7;  r1_b = 32'd2;  r1_ctrl = 4'd1; r1_req_valid = 1;
        r1_resp_ready = 1;   // non-owner ready must be ignored
        #1;
        chk("t5_tie_r0", {r0_req_ready, r1_req_ready}, 2'b10);
        step();
        r0_req_valid = 0;
        #1;
        chk("t5_exec_r1_blocked", r1_req_ready, 1'b0);
        step();
        chk("t5_resp", r0_resp_valid, 1'b1);
        held = r0_result;
        chk("t5_result", held, 32'd30);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t5_hold%0d", i), {r0_resp_valid, r1_req_ready, r0_result}, {2'b10, 32'd30});
        end
        r0_resp_ready = 1;
        step();
        r0_resp_ready = 0;
        #1;
        chk("t5_r1_accept", {r0_resp_valid, r1_req_ready}, 2'b01);
        step();
        r1_req_valid = 0;
        step();
        chk("t5_r1_resp", {r1_resp_valid, r1_result}, {1'b1, 32'd5});
        step();
        idle_inputs();
        step();

        // Async reset in EXEC kills the op
        r0_a = 32'd9; r0_b = 32'd9; r0_ctrl = 4'd0; r0_req_valid = 1; r0_resp_ready = 1;
        step();
        r0_req_valid = 0;
        #1;
        chk("t6_in_exec_alu", alu_a, 32'd9);
        #2;
        rst_n = 0;
        #1;
        chk("t6_async_out", {r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid}, 4'b0000);
        chk("t6_async_regs", {alu_a, alu_b, r0_result}, 96'd0);
        step();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t6_no_resp%0d", i), {r0_resp_valid, r1_resp_valid}, 2'b00);
        end
        r0_req_valid = 1; r1_req_valid = 1;
        #1;
        chk("t6_tie_r0", {r0_req_ready, r1_req_ready}, 2'b10);
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
